mc_controller: RTL and testbench

Multicycle control unit for the ARM-subset datapath. It sequences one shared memory port, one ALU and the register file across Fetch/Decode/Execute/Writeback states. It waits on a memory-ready handshake and applies ARM conditional execution through internally held NZCV flags. It sits beside the multicycle datapath and replaces the single-cycle controller/decoder/condlogic trio.

---
 rtl/mc_controller_if.sv | 30 +++
 rtl/mc_controller.sv | 183 ++++++++++++++++++
 tb/tb_mc_controller.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller takes the master modport; the datapath side takes slave.
interface mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: Fetch/Decode/Execute/Writeback sequencing with NZCV conditional execution.
// Optional feature macro MC_CTRL_CMP_EN: treats DP cmd 1010 with S=1 as CMP (flags only, no writeback).
module mc_controller (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI, ALUWB, BRANCH
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_ORR = 4'b0011
  } alu_op_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t     state;
  logic [3:0] flags;   // {N,Z,C,V}
  logic       condex;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       i_bit, s_bit, rd_pc, is_cmp, dp_valid, flag_cv;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign i_bit = bus.Instr[25];
  assign cmd   = bus.Instr[24:21];
  assign s_bit = bus.Instr[20];   // doubles as L for memory instructions
  assign rd_pc = (bus.Instr[15:12] == 4'hF);

`ifdef MC_CTRL_CMP_EN
  assign is_cmp = (cmd == 4'b1010) && s_bit;
`else
  assign is_cmp = 1'b0;
`endif

  assign dp_valid = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                    (cmd == CMD_ORR) || is_cmp;
  assign flag_cv  = (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:0]};

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: return z;
      4'b0001: return !z;
      4'b0010: return cy;
      4'b0011: return !cy;
      4'b0100: return n;
      4'b0101: return !n;
      4'b0110: return v;
      4'b0111: return !v;
      4'b1000: return cy && !z;
      4'b1001: return !cy || z;
      4'b1010: return n == v;
      4'b1011: return n != v;
      4'b1100: return !z && (n == v);
      4'b1101: return z || (n != v);
      4'b1110: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      flags  <= 4'b0000;
      condex <= 1'b0;
    end else begin
      case (state)
        FETCH:  if (bus.MemReady) state <= DECODE;
        DECODE: begin
          condex <= cond_check(cond, flags);
          case (op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= !dp_valid ? FETCH : (i_bit ? EXEI : EXER);
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR: state <= s_bit ? MEMRD : MEMWR;
        MEMRD:  if (bus.MemReady) state <= MEMWB;
        MEMWR:  if (bus.MemReady) state <= FETCH;
        EXER, EXEI: begin
          if (s_bit && condex) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (flag_cv) flags[1:0] <= bus.ALUFlags[1:0];
          end
          state <= is_cmp ? FETCH : ALUWB;
        end
        default: state <= FETCH;   // MEMWB, ALUWB, BRANCH
      endcase
    end
  end

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, src_a;
  logic [1:0] result_src, src_b;
  alu_op_t    alu_ctrl;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    src_a      = 1'b0;
    src_b      = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (state)
      FETCH: begin
        src_a      = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
      end
      DECODE: begin
        src_a      = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
      end
      MEMADR: src_b = 2'b01;
      MEMRD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        pc_write   = condex && rd_pc;
        reg_write  = condex && !rd_pc;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = condex;
      end
      EXER, EXEI: begin
        src_b = (state == EXEI) ? 2'b01 : 2'b00;
        if (is_cmp || cmd == CMD_SUB) alu_ctrl = ALU_SUB;
        else if (cmd == CMD_AND)      alu_ctrl = ALU_AND;
        else if (cmd == CMD_ORR)      alu_ctrl = ALU_ORR;
      end
      ALUWB: begin
        pc_write  = condex && rd_pc;
        reg_write = condex && !rd_pc;
      end
      BRANCH: begin
        src_b      = 2'b01;
        result_src = 2'b10;
        pc_write   = condex;
      end
      default: ;
    endcase
    // Reset is asynchronous, so strobes are gated directly rather than waiting for a clock.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctrl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle control words checked against hand-derived constants.
// Expectations for CMP follow MC_CTRL_CMP_EN as seen by this compile.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   failures = 0;

  mc_controller_if bus ();

  mc_controller u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
  logic [13:0] ctl;
  assign ctl = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl};

  localparam logic [13:0] F_GO   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0000};
  localparam logic [13:0] F_WAIT = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0000};
  localparam logic [13:0] F_RST  = F_WAIT;
  localparam logic [13:0] DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 4'b0000};
  localparam logic [13:0] MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0000};
  localparam logic [13:0] MRD    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] MWR1   = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] MWR0   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] EX_ADD = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] EX_SUBR= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0001};
  localparam logic [13:0] EX_SUBI= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b0001};
  localparam logic [13:0] EX_AND = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0010};
  localparam logic [13:0] EX_ORR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0011};
  localparam logic [13:0] AWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] AWB_PC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000};
  localparam logic [13:0] BR1    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0000};
  localparam logic [13:0] BR0    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 4'b0000};

  localparam logic [31:0] I_NOP  = 32'hEC000000;
  localparam logic [31:0] I_ADDS = 32'hE0921003;
  localparam logic [31:0] I_LDR  = 32'hE5921004;
  localparam logic [31:0] I_STR  = 32'hE5821004;
  localparam logic [31:0] I_STREQ= 32'h05821004;
  localparam logic [31:0] I_B    = 32'hEA000002;
  localparam logic [31:0] I_BNE  = 32'h1A000002;
  localparam logic [31:0] I_BEQ  = 32'h0A000002;
  localparam logic [31:0] I_BMI  = 32'h4A000002;
  localparam logic [31:0] I_BCS  = 32'h2A000002;
  localparam logic [31:0] I_BNV  = 32'hFA000002;
  localparam logic [31:0] I_CMP  = 32'hE1510002;
  localparam logic [31:0] I_ORRS = 32'hE1921003;

  // Drive one cycle's inputs just after the falling edge; outputs are then read 1 time unit later.
  task automatic step(input logic [31:0] instr, input logic rdy, input logic [3:0] fl);
    @(negedge clk);
    bus.Instr    = instr;
    bus.MemReady = rdy;
    bus.ALUFlags = fl;
    #1;
  endtask

  task automatic test_reset();
    step(I_NOP, 1'b1, 4'b0000);
    vectors++;
    if (ctl !== F_RST) begin
      failures++;
      $display("FAIL reset_strobes: ctl=%b expected=%b", ctl, F_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.Instr = I_NOP;
    bus.MemReady = 1'b1;
    #1;
    vectors++;
    if (ctl !== F_GO) begin
      failures++;
      $display("FAIL first_fetch: ctl=%b expected=%b", ctl, F_GO);
    end
    step(I_NOP, 1'b1, 4'b0000);
    vectors++;
    if (ctl !== DEC) begin
      failures++;
      $display("FAIL nop_decode: ctl=%b expected=%b", ctl, DEC);
    end
  endtask

  task automatic test_str_cond_fail();
    logic [13:0] exp [5] = '{F_GO, DEC, MADR, MWR0, MWR0};
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (exp[i]) begin
      step(I_STREQ, rdy[i], 4'b0000);
      vectors++;
      if (ctl !== exp[i]) begin
        failures++;
        $display("FAIL streq_z0 cycle %0d: ctl=%b expected=%b", i, ctl, exp[i]);
      end
    end
  endtask

  task automatic test_flag_cv_mask();
    logic [13:0] exp_orr [4] = '{F_GO, DEC, EX_ORR, AWB};
    logic [13:0] exp_bcs [3] = '{F_GO, DEC, BR0};
    foreach (exp_orr[i]) begin
      step(I_ORRS, 1'b1, 4'b1111);
      vectors++;
      if (ctl !== exp_orr[i]) begin
        failures++;
        $display("FAIL orrs cycle %0d: ctl=%b expected=%b", i, ctl, exp_orr[i]);
      end
    end
    foreach (exp_bcs[i]) begin
      step(I_BCS, 1'b1, 4'b0000);
      vectors++;
      if (ctl !== exp_bcs[i]) begin
        failures++;
        $display("FAIL bcs_after_orrs cycle %0d: ctl=%b expected=%b", i, ctl, exp_bcs[i]);
      end
    end
  endtask

  task automatic test_adds();
    logic [13:0] exp [4] = '{F_GO, DEC, EX_ADD, AWB};
    foreach (exp[i]) begin
      step(I_ADDS, 1'b1, 4'b0100);
      vectors++;
      if (ctl !== exp[i]) begin
        failures++;
        $display("FAIL adds cycle %0d: ctl=%b expected=%b", i, ctl, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [3]    = '{I_BNE, I_B, I_BNV};
    logic [13:0] exp [3][3] = '{'{F_GO, DEC, BR0}, '{F_GO, DEC, BR1}, '{F_GO, DEC, BR0}};
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) begin
        step(ins[b], 1'b1, 4'b0000);
        vectors++;
        if (ctl !== exp[b][i]) begin
          failures++;
          $display("FAIL branch %0d cycle %0d: ctl=%b expected=%b", b, i, ctl, exp[b][i]);
        end
      end
    end
  endtask

  task automatic test_dp_variants();
    logic [31:0] ins [6]    = '{32'hE2421001, 32'hE0021003, 32'hE1821003,
                                32'hE082F003, 32'hE0221003, I_NOP};
    logic [13:0] exp [6][4] = '{'{F_GO, DEC, EX_SUBI, AWB},
                                '{F_GO, DEC, EX_AND, AWB},
                                '{F_GO, DEC, EX_ORR, AWB},
                                '{F_GO, DEC, EX_ADD, AWB_PC},
                                '{F_GO, DEC, F_GO, DEC},
                                '{F_GO, DEC, F_GO, DEC}};
    for (int d = 0; d < 6; d++) begin
      for (int i = 0; i < 4; i++) begin
        step(ins[d], 1'b1, 4'b0000);
        vectors++;
        if (ctl !== exp[d][i]) begin
          failures++;
          $display("FAIL dp %0d cycle %0d: ctl=%b expected=%b", d, i, ctl, exp[d][i]);
        end
      end
    end
  endtask

  task automatic test_ldr();
    logic [13:0] exp [7] = '{F_GO, DEC, MADR, MRD, MRD, MRD, MWB};
    logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    foreach (exp[i]) begin
      step(I_LDR, rdy[i], 4'b0000);
      vectors++;
      if (ctl !== exp[i]) begin
        failures++;
        $display("FAIL ldr cycle %0d: ctl=%b expected=%b", i, ctl, exp[i]);
      end
    end
  endtask

  task automatic test_str();
    logic [13:0] exp [6] = '{F_WAIT, F_GO, DEC, MADR, MWR1, MWR1};
    logic        rdy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (exp[i]) begin
      step(I_STR, rdy[i], 4'b0000);
      vectors++;
      if (ctl !== exp[i]) begin
        failures++;
        $display("FAIL str cycle %0d: ctl=%b expected=%b", i, ctl, exp[i]);
      end
    end
  endtask

  task automatic test_cmp();
`ifdef MC_CTRL_CMP_EN
    logic [13:0] exp_cmp [3] = '{F_GO, DEC, EX_SUBR};
    logic [13:0] exp_bmi [3] = '{F_GO, DEC, BR1};
    logic [13:0] exp_beq [3] = '{F_GO, DEC, BR0};
`else
    logic [13:0] exp_cmp [2] = '{F_GO, DEC};
    logic [13:0] exp_bmi [3] = '{F_GO, DEC, BR0};
    logic [13:0] exp_beq [3] = '{F_GO, DEC, BR1};
`endif
    foreach (exp_cmp[i]) begin
      step(I_CMP, 1'b1, 4'b1000);
      vectors++;
      if (ctl !== exp_cmp[i]) begin
        failures++;
        $display("FAIL cmp cycle %0d: ctl=%b expected=%b", i, ctl, exp_cmp[i]);
      end
    end
    foreach (exp_bmi[i]) begin
      step(I_BMI, 1'b1, 4'b0000);
      vectors++;
      if (ctl !== exp_bmi[i]) begin
        failures++;
        $display("FAIL bmi_after_cmp cycle %0d: ctl=%b expected=%b", i, ctl, exp_bmi[i]);
      end
    end
    foreach (exp_beq[i]) begin
      step(I_BEQ, 1'b1, 4'b0000);
      vectors++;
      if (ctl !== exp_beq[i]) begin
        failures++;
        $display("FAIL beq_after_cmp cycle %0d: ctl=%b expected=%b", i, ctl, exp_beq[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [13:0] exp_str [4] = '{F_GO, DEC, MADR, MWR1};
    logic        rdy_str [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [13:0] exp_beq [3] = '{DEC, BR0, F_GO};
    foreach (exp_str[i]) begin
      step(I_STR, rdy_str[i], 4'b0000);
      vectors++;
      if (ctl !== exp_str[i]) begin
        failures++;
        $display("FAIL abort_str cycle %0d: ctl=%b expected=%b", i, ctl, exp_str[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    vectors++;
    if (ctl !== F_RST) begin
      failures++;
      $display("FAIL abort_in_reset: ctl=%b expected=%b", ctl, F_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.Instr = I_BEQ;
    #1;
    vectors++;
    if (ctl !== F_GO) begin
      failures++;
      $display("FAIL abort_refetch: ctl=%b expected=%b", ctl, F_GO);
    end
    // Flags were cleared by reset, so BEQ must not be taken.
    foreach (exp_beq[i]) begin
      step(I_BEQ, 1'b1, 4'b0000);
      vectors++;
      if (ctl !== exp_beq[i]) begin
        failures++;
        $display("FAIL beq_after_reset cycle %0d: ctl=%b expected=%b", i, ctl, exp_beq[i]);
      end
    end
  endtask

  task automatic test_fields();
    logic [31:0] ins [3] = '{I_LDR, I_B, I_ADDS};
    logic [3:0]  exp [3] = '{4'b0110, 4'b1001, 4'b0000};  // {ImmSrc, RegSrc}
    foreach (ins[i]) begin
      bus.Instr = ins[i];
      #1;
      vectors++;
      if ({bus.ImmSrc, bus.RegSrc} !== exp[i]) begin
        failures++;
        $display("FAIL fields %0d: imm_reg=%b expected=%b", i, {bus.ImmSrc, bus.RegSrc}, exp[i]);
      end
    end
  endtask

  initial begin
    bus.Instr    = I_NOP;
    bus.MemReady = 1'b1;
    bus.ALUFlags = 4'b0000;
    test_reset();
    test_str_cond_fail();
    test_flag_cv_mask();
    test_adds();
    test_branch();
    test_dp_variants();
    test_ldr();
    test_str();
    test_cmp();
    test_reset_abort();
    test_fields();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
